// File: rtl/dendy_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dendy_bus_pkg
// Purpose  : Shared definitions for the Dendy CPU bus responder.
//            - CPU address-map constants
//            - PPU register index used by OAM DMA
//            - OAM DMA state encoding
//            - Bus target selector and address decoder
// Revision : 1.0 - initial release
// ============================================================================
package dendy_bus_pkg;

    localparam logic [15:0] RAM_END   = 16'h1FFF;
    localparam logic [15:0] PPU_BASE  = 16'h2000;
    localparam logic [15:0] PPU_END   = 16'h3FFF;
    localparam logic [15:0] OAM_DMA   = 16'h4014;
    localparam logic [15:0] JOY1      = 16'h4016;
    localparam logic [15:0] JOY2      = 16'h4017;
    localparam logic [15:0] CART_BASE = 16'h4020;

    localparam logic [2:0]  PPU_OAMDATA = 3'd4;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_ALIGN = 2'd1,
        DMA_READ  = 2'd2,
        DMA_WRITE = 2'd3
    } dma_state_e;

    typedef enum logic [2:0] {
        SEL_RAM  = 3'd0,
        SEL_PPU  = 3'd1,
        SEL_JOY1 = 3'd2,
        SEL_JOY2 = 3'd3,
        SEL_CART = 3'd4,
        SEL_NONE = 3'd5
    } bus_sel_e;

    // $4014 decodes to SEL_NONE: its only effect is arming DMA, and a read
    // of it is open bus.
    function automatic bus_sel_e decode(input logic [15:0] addr);
        bus_sel_e sel;
        if (addr <= RAM_END)         sel = SEL_RAM;
        else if (addr <= PPU_END)    sel = SEL_PPU;
        else if (addr == JOY1)       sel = SEL_JOY1;
        else if (addr == JOY2)       sel = SEL_JOY2;
        else if (addr >= CART_BASE)  sel = SEL_CART;
        else                         sel = SEL_NONE;
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dendy_oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : dendy_oam_dma
// Purpose  : $4014 OAM DMA engine. Copies page V ($VV00-$VVFF) to PPU
//            OAMDATA, one READ and one WRITE CPU cycle per byte, after a 1 or
//            2 cycle ALIGN depending on the CPU-cycle parity at arm time.
// Ports    : clock, reset_n  - system clock, async active-low reset
//            tick            - CE tick (end of every CPU cycle, even stalled)
//            arm, page       - CPU write to $4014 commit and its data
//            rdata           - bus read data for the current owner address
//            dma_active      - engine owns the bus
//            dma_addr        - bus address requested by the engine
//            dma_data        - byte fetched in READ, written in WRITE
//            dma_rd, dma_wr  - one-clock read / write commit strobes
// Revision : 1.0 - initial release
// ============================================================================
module dendy_oam_dma
    import dendy_bus_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        arm,
    input  logic [7:0]  page,
    input  logic [7:0]  rdata,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_data,
    output logic        dma_rd,
    output logic        dma_wr
);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       parity_q, parity_d;
    logic       extra_q, extra_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= DMA_IDLE;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            data_q   <= 8'h00;
            parity_q <= 1'b0;
            extra_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            extra_q  <= extra_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        idx_d    = idx_q;
        data_d   = data_q;
        extra_d  = extra_q;
        // Parity of the current CPU cycle; keeps toggling during the stall.
        parity_d = parity_q ^ tick;
        case (state_q)
            DMA_IDLE: begin
                if (arm) begin
                    state_d = DMA_ALIGN;
                    page_d  = page;
                    idx_d   = 8'h00;
                    // Arming on an odd cycle costs one extra align cycle.
                    extra_d = parity_q;
                end
            end
            DMA_ALIGN: begin
                if (tick) begin
                    if (extra_q) extra_d = 1'b0;
                    else         state_d = DMA_READ;
                end
            end
            DMA_READ: begin
                if (tick) begin
                    data_d  = rdata;
                    state_d = DMA_WRITE;
                end
            end
            DMA_WRITE: begin
                if (tick) begin
                    if (idx_q == 8'hFF) begin
                        state_d = DMA_IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = DMA_READ;
                    end
                end
            end
            default: state_d = DMA_IDLE;
        endcase
    end

    assign dma_active = (state_q != DMA_IDLE);
    // WRITE targets $2004 so the normal decode steers it to PPU OAMDATA.
    assign dma_addr   = (state_q == DMA_WRITE) ? {PPU_BASE[15:3], PPU_OAMDATA}
                                               : {page_q, idx_q};
    assign dma_data   = data_q;
    assign dma_rd     = tick && (state_q == DMA_READ);
    assign dma_wr     = tick && (state_q == DMA_WRITE);

endmodule
`default_nettype wire

// File: rtl/dendy_bus.sv
`default_nettype none
// ============================================================================
// Module   : dendy_bus
// Purpose  : CPU-side bus responder for the Dendy core: work RAM, PPU window,
//            joypads, OAM DMA, cartridge routing and CPU clock-enable.
// Ports    : clock/reset_n (async active-low); cpu_a/d/r/w in, cpu_i/cpu_ce
//            out; ppu_a/d/rd/wr out, ppu_i in; cart_a/d/wr out, cart_i in;
//            joy1/joy2 pad buttons; dma_active.
// Options  : DENDY_OPEN_BUS_EN - unmapped reads and joypad upper bits return
//            the last data-bus value instead of fixed constants.
// Revision : 1.0 - initial release
// ============================================================================
module dendy_bus
    import dendy_bus_pkg::*;
#(
    parameter int CE_DIV = 12,
    parameter int RAM_AW = 11
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_r,
    input  logic        cpu_w,
    output logic [7:0]  cpu_i,
    output logic        cpu_ce,
    output logic [2:0]  ppu_a,
    output logic [7:0]  ppu_d,
    input  logic [7:0]  ppu_i,
    output logic        ppu_rd,
    output logic        ppu_wr,
    output logic [15:0] cart_a,
    output logic [7:0]  cart_d,
    input  logic [7:0]  cart_i,
    output logic        cart_wr,
    input  logic [7:0]  joy1,
    input  logic [7:0]  joy2,
    output logic        dma_active
);

    localparam int DIV_W = $clog2(CE_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       cpu_i_q, cpu_i_d;
    logic [7:0]       sh1_q, sh1_d, sh2_q, sh2_d;
    logic             strobe_q, strobe_d;
    logic [7:0]       ram_mem [0:(1<<RAM_AW)-1];

    logic             tick, cpu_rd_c, cpu_wr_c, rd_commit, wr_commit, ram_we;
    logic [15:0]      owner_a, dma_addr;
    logic [7:0]       wdata, rdata, dma_data, unmapped;
    logic [6:0]       joy_hi;
    logic             dma_rd, dma_wr;
    bus_sel_e         sel;

    // ---------------- clock enable ----------------
    assign tick     = (div_q == DIV_W'(CE_DIV - 1));
    assign div_d    = tick ? '0 : div_q + 1'b1;
    assign cpu_ce   = tick && !dma_active;
    assign cpu_rd_c = cpu_ce && cpu_r;
    assign cpu_wr_c = cpu_ce && cpu_w;

    // ---------------- bus ownership / decode ----------------
    assign owner_a   = dma_active ? dma_addr : cpu_a;
    assign wdata     = dma_active ? dma_data : cpu_d;
    assign sel       = decode(owner_a);
    assign rd_commit = cpu_rd_c || dma_rd;
    assign wr_commit = cpu_wr_c || dma_wr;
    assign ram_we    = wr_commit && (sel == SEL_RAM);

    assign ppu_a   = owner_a[2:0];
    assign ppu_d   = wdata;
    assign ppu_rd  = rd_commit && (sel == SEL_PPU);
    assign ppu_wr  = wr_commit && (sel == SEL_PPU);
    assign cart_a  = owner_a;
    assign cart_d  = wdata;
    assign cart_wr = wr_commit && (sel == SEL_CART);

    dendy_oam_dma u_dma (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick       (tick),
        .arm        (cpu_wr_c && (cpu_a == OAM_DMA)),
        .page       (cpu_d),
        .rdata      (rdata),
        .dma_active (dma_active),
        .dma_addr   (dma_addr),
        .dma_data   (dma_data),
        .dma_rd     (dma_rd),
        .dma_wr     (dma_wr)
    );

    // ---------------- open bus ----------------
`ifdef DENDY_OPEN_BUS_EN
    logic [7:0] bus_q, bus_d;

    always_comb begin
        bus_d = bus_q;
        if (wr_commit)      bus_d = wdata;
        else if (rd_commit) bus_d = rdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) bus_q <= 8'hFF;
        else          bus_q <= bus_d;
    end

    assign unmapped = bus_q;
    assign joy_hi   = bus_q[7:1];
`else
    assign unmapped = 8'hFF;
    assign joy_hi   = 7'b0100000;
`endif

    // ---------------- joypads ----------------
    always_comb begin
        strobe_d = strobe_q;
        sh1_d    = sh1_q;
        sh2_d    = sh2_q;
        if (wr_commit && (sel == SEL_JOY1)) strobe_d = wdata[0];
        // While strobed the pads are transparent; the 1->0 edge leaves the
        // last sampled state in the shifters.
        if (strobe_q) begin
            sh1_d = joy1;
            sh2_d = joy2;
        end else if (rd_commit && (sel == SEL_JOY1)) begin
            sh1_d = {1'b1, sh1_q[7:1]};
        end else if (rd_commit && (sel == SEL_JOY2)) begin
            sh2_d = {1'b1, sh2_q[7:1]};
        end
    end

    // ---------------- read data ----------------
    always_comb begin
        case (sel)
            SEL_RAM:  rdata = ram_mem[owner_a[RAM_AW-1:0]];
            SEL_PPU:  rdata = ppu_i;
            SEL_JOY1: rdata = {joy_hi, sh1_q[0]};
            SEL_JOY2: rdata = {joy_hi, sh2_q[0]};
            SEL_CART: rdata = cart_i;
            default:  rdata = unmapped;
        endcase
        cpu_i_d = rdata;
    end

    assign cpu_i = cpu_i_q;

    // ---------------- registers ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= '0;
            cpu_i_q  <= 8'hFF;
            sh1_q    <= 8'h00;
            sh2_q    <= 8'h00;
            strobe_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            cpu_i_q  <= cpu_i_d;
            sh1_q    <= sh1_d;
            sh2_q    <= sh2_d;
            strobe_q <= strobe_d;
        end
    end

    // Work RAM contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_we) ram_mem[owner_a[RAM_AW-1:0]] <= wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_dendy_bus.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dendy_bus
// Purpose  : Directed self-checking bench for dendy_bus: reset state, RAM
//            mirroring, PPU/cart strobes, joypad shifting, OAM DMA (even and
//            odd start) and reset during DMA.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dendy_bus;

    localparam int CE_DIV = 12;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic        cpu_r, cpu_w;
    logic [7:0]  cpu_i;
    logic        cpu_ce;
    logic [2:0]  ppu_a;
    logic [7:0]  ppu_d, ppu_i;
    logic        ppu_rd, ppu_wr;
    logic [15:0] cart_a;
    logic [7:0]  cart_d, cart_i;
    logic        cart_wr;
    logic [7:0]  joy1, joy2;
    logic        dma_active;

    dendy_bus #(.CE_DIV(CE_DIV), .RAM_AW(11)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_a      (cpu_a),
        .cpu_d      (cpu_d),
        .cpu_r      (cpu_r),
        .cpu_w      (cpu_w),
        .cpu_i      (cpu_i),
        .cpu_ce     (cpu_ce),
        .ppu_a      (ppu_a),
        .ppu_d      (ppu_d),
        .ppu_i      (ppu_i),
        .ppu_rd     (ppu_rd),
        .ppu_wr     (ppu_wr),
        .cart_a     (cart_a),
        .cart_d     (cart_d),
        .cart_i     (cart_i),
        .cart_wr    (cart_wr),
        .joy1       (joy1),
        .joy2       (joy2),
        .dma_active (dma_active)
    );

    always #20 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference CE model: CPU-cycle count since reset, for DMA parity choice.
    int m_div = 0;
    int m_ticks = 0;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_div   <= 0;
            m_ticks <= 0;
        end else if (m_div == CE_DIV - 1) begin
            m_div   <= 0;
            m_ticks <= m_ticks + 1;
        end else begin
            m_div   <= m_div + 1;
        end
    end

    // Strobe monitors, sampled mid-clock.
    int         rd_n = 0, wr_n = 0, cart_n = 0;
    logic [2:0] last_rd_a, last_wr_a;
    logic [7:0] last_wr_d, last_cart_d;
    logic [15:0] last_cart_a;
    logic [2:0] log_a [0:1023];
    logic [7:0] log_d [0:1023];
    always @(negedge clock) begin
        if (ppu_rd) begin
            rd_n++;
            last_rd_a = ppu_a;
        end
        if (ppu_wr) begin
            log_a[wr_n % 1024] = ppu_a;
            log_d[wr_n % 1024] = ppu_d;
            last_wr_a = ppu_a;
            last_wr_d = ppu_d;
            wr_n++;
        end
        if (cart_wr) begin
            last_cart_a = cart_a;
            last_cart_d = cart_d;
            cart_n++;
        end
    end

    // Wait for the next CE commit edge, return 1 ns after it.
    task automatic wait_ce();
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!cpu_ce && k < 8000);
        if (!cpu_ce) check("ce_timeout", cpu_ce, 1);
        @(posedge clock);
        #1;
    endtask

    // One CPU bus cycle; strobes drop after the commit edge.
    task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w);
        cpu_a = a; cpu_d = d; cpu_r = r; cpu_w = w;
        wait_ce();
        cpu_r = 1'b0;
        cpu_w = 1'b0;
    endtask

    task automatic run_dma(input int want_odd, input int exp_stall, input string tag);
        int base, n, bad_a;
        if ((m_ticks % 2) != want_odd) bus(16'h0000, 8'h00, 1'b1, 1'b0);
        base = wr_n;
        bus(16'h4014, 8'h02, 1'b0, 1'b1);
        check({tag, "_active"}, dma_active, 1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!cpu_ce && n < 8000);
        @(posedge clock);
        #1;
        check({tag, "_stall"}, n / CE_DIV - 1, exp_stall);
        check({tag, "_done"}, dma_active, 0);
        check({tag, "_nwr"}, wr_n - base, 256);
        bad_a = 0;
        for (int i = 0; i < 256; i++) begin
            if (log_a[(base + i) % 1024] !== 3'd4) bad_a++;
            check({tag, "_data"}, log_d[(base + i) % 1024], 32'(i[7:0] ^ 8'hA5));
        end
        check({tag, "_ppu_a"}, bad_a, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, w0, c0, k, ce_n, first_j, last_j, wr_at_rst;
        logic [8:0] joy_seq;

        reset_n = 1'b0;
        cpu_a = 16'h0000; cpu_d = 8'h00; cpu_r = 1'b0; cpu_w = 1'b0;
        ppu_i = 8'h3C; cart_i = 8'h77;
        joy1 = 8'b1000_0001; joy2 = 8'h00;

        repeat (3) @(negedge clock);
        check("rst_cpu_i", cpu_i, 8'hFF);
        check("rst_cpu_ce", cpu_ce, 0);
        check("rst_dma", dma_active, 0);
        check("rst_strobes", {ppu_rd, ppu_wr, cart_wr}, 0);
        reset_n = 1'b1;

        // RAM mirror
        w0 = wr_n; c0 = cart_n;
        bus(16'h0123, 8'h5A, 1'b0, 1'b1);
        check("ram_wr_no_side", (wr_n - w0) + (cart_n - c0), 0);
        bus(16'h0923, 8'h00, 1'b1, 1'b0);
        check("ram_mirror_0923", cpu_i, 8'h5A);
        bus(16'h1923, 8'h00, 1'b1, 1'b0);
        check("ram_mirror_1923", cpu_i, 8'h5A);

        // PPU read / write strobes
        r0 = rd_n;
        bus(16'h3FFA, 8'h00, 1'b1, 1'b0);
        check("ppu_rd_count", rd_n - r0, 1);
        check("ppu_rd_a", last_rd_a, 3'd2);
        check("ppu_rd_data", cpu_i, 8'h3C);
        w0 = wr_n;
        bus(16'h2006, 8'h21, 1'b0, 1'b1);
        check("ppu_wr_count", wr_n - w0, 1);
        check("ppu_wr_a", last_wr_a, 3'd6);
        check("ppu_wr_d", last_wr_d, 8'h21);

        // Joypad: strobe, then nine reads
        bus(16'h4016, 8'h01, 1'b0, 1'b1);
        bus(16'h4016, 8'h00, 1'b0, 1'b1);
        joy1 = 8'h00;
        joy_seq = 9'b1_1000_0001;
        for (int i = 0; i < 9; i++) begin
            bus(16'h4016, 8'h00, 1'b1, 1'b0);
            check("joy1_read", cpu_i, {7'b0100000, joy_seq[i]});
        end
        bus(16'h4017, 8'h00, 1'b1, 1'b0);
        check("joy2_read", cpu_i, 8'h40);

        // Unmapped and cartridge
        bus(16'h4000, 8'h00, 1'b1, 1'b0);
        check("unmapped_read", cpu_i, 8'hFF);
        w0 = wr_n; c0 = cart_n;
        bus(16'h4015, 8'h33, 1'b0, 1'b1);
        check("unmapped_wr_ignored", (wr_n - w0) + (cart_n - c0), 0);
        bus(16'hC000, 8'h00, 1'b1, 1'b0);
        check("cart_read", cpu_i, 8'h77);
        c0 = cart_n;
        bus(16'h8000, 8'h99, 1'b0, 1'b1);
        check("cart_wr_count", cart_n - c0, 1);
        check("cart_wr_a", last_cart_a, 16'h8000);
        check("cart_wr_d", last_cart_d, 8'h99);

        // Preload $0200-$02FF
        for (int i = 0; i < 256; i++)
            bus(16'h0200 + 16'(i), i[7:0] ^ 8'hA5, 1'b0, 1'b1);
        bus(16'h0A05, 8'h00, 1'b1, 1'b0);
        check("preload_mirror", cpu_i, 8'hA0);

        run_dma(0, 513, "dma_even");
        run_dma(1, 514, "dma_odd");

        // Reset in the middle of a DMA
        bus(16'h4014, 8'h02, 1'b0, 1'b1);
        w0 = wr_n;
        k = 0;
        while ((wr_n - w0) < 100 && k < 8000) begin
            @(negedge clock);
            k++;
        end
        check("mid_dma_reached", wr_n - w0, 100);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_dma_active", dma_active, 0);
        check("rst_mid_strobes", {ppu_rd, ppu_wr, cart_wr, cpu_ce}, 0);
        wr_at_rst = wr_n;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        ce_n = 0; first_j = -1; last_j = -1;
        for (int j = 1; j <= 20 * CE_DIV; j++) begin
            @(negedge clock);
            if (cpu_ce) begin
                ce_n++;
                if (first_j < 0) first_j = j;
                last_j = j;
            end
        end
        check("post_rst_ce_count", ce_n, 20);
        check("post_rst_ce_first", first_j, CE_DIV - 1);
        check("post_rst_ce_span", last_j - first_j, 19 * CE_DIV);
        check("post_rst_no_ppu_wr", wr_n - wr_at_rst, 0);
        check("post_rst_dma", dma_active, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dendy_bus.md
Name: dendy_bus

Overview:
- CPU-side bus responder for the Dendy core. It decodes every CPU access (A/D/R/W) and returns read data on I.
- Owns the 2 KB work RAM, the PPU register window, joypad ports and the $4014 OAM DMA engine.
- Generates the CPU clock-enable and stalls the CPU during DMA.
- Routes $4020–$FFFF to the cartridge port.

Parameters:
- CE_DIV, 12, clock cycles per CPU cycle; minimum 3, giving 25 MHz / 12 ≈ 2.08 MHz.
- RAM_AW, 11, work-RAM address width; 2 KB, mirrored across $0000–$1FFF.

Ports:
- clock  in  1  system clock, 25 MHz
- reset_n  in  1  asynchronous active-low reset
- cpu_a  in  16  CPU address
- cpu_d  in  8  CPU write data
- cpu_r  in  1  CPU read strobe, registered in the CPU, held for one CPU cycle
- cpu_w  in  1  CPU write strobe, same timing as cpu_r
- cpu_i  out  8  read data to CPU
- cpu_ce  out  1  CPU clock-enable pulse
- ppu_a  out  3  PPU register index
- ppu_d  out  8  PPU write data
- ppu_i  in  8  PPU read data
- ppu_rd  out  1  one-clock PPU read strobe
- ppu_wr  out  1  one-clock PPU write strobe
- cart_a  out  16  cartridge address
- cart_d  out  8  cartridge write data
- cart_i  in  8  cartridge read data
- cart_wr  out  1  one-clock cartridge write strobe
- joy1  in  8  pad 1 buttons, bit0=A … bit7=Right, 1=pressed
- joy2  in  8  pad 2 buttons, same encoding
- dma_active  out  1  high while OAM DMA owns the bus

Behaviour:
- Reset (async, reset_n=0):
  - Divider and DMA FSM cleared; cpu_ce=0.
  - All strobes 0; cpu_i=8'hFF.
  - Joypad shift registers 8'h00, strobe latch 0, dma_active=0.
- CE: divider counts 0..CE_DIV-1. cpu_ce=1 for one clock at count CE_DIV-1, except when dma_active=1, where cpu_ce=0.
- Bus owner: the CPU, or the DMA engine when dma_active=1. The owner's address drives the decode.
- Address map:
  - $0000–$1FFF: RAM at addr[RAM_AW-1:0].
  - $2000–$3FFF: PPU, index addr[2:0].
  - $4014: DMA page register.
  - $4016: joypad 1 data / strobe.
  - $4017: joypad 2 data.
  - $4020–$FFFF: cartridge.
  - Everything else in $4000–$401F reads open-bus and ignores writes (APU lives elsewhere).
- Read timing: read data is registered every clock from the current address. cpu_i is valid 1 clock after the address changes, so it is stable well before the next cpu_ce.
  - ppu_rd pulses exactly once per CPU read cycle, on the clock where cpu_ce=1 and cpu_r=1. This protects $2002/$2007 side effects.
  - cpu_i returns ppu_i registered on that same clock.
- Write commit: exactly once per access, on the clock where cpu_ce=1 and cpu_w=1. The target gets a one-clock strobe; writes are never repeated while W stays high across gap clocks.
- Joypad:
  - A write to $4016 sets the strobe latch to D[0]. While the latch is 1, sh1=joy1 and sh2=joy2 every clock.
  - On the 1→0 transition of the latch, the pads are latched.
  - A read of $4016/$4017 returns {7'b0100000, sh[0]}, then shifts right with 1 inserted after the commit clock.
  - After 8 reads, further reads return bit0=1.
- OAM DMA:
  - A write of V to $4014 arms DMA. dma_active rises at the end of that CPU cycle.
  - States: IDLE → ALIGN → READ ↔ WRITE → IDLE. Each state lasts one CE period.
  - ALIGN lasts 1 CPU cycle, or 2 if the DMA starts on an odd CPU cycle; a CPU-cycle parity bit toggles on every CE tick.
  - READ fetches {V,i} through the normal decode; RAM, PPU and cart reads are all legal.
  - WRITE writes the fetched byte to PPU index 4 (ppu_wr, ppu_a=3'd4, ppu_d=byte).
  - i runs 0..255; after WRITE with i=255 the FSM returns to IDLE.
  - Total stall is 513 CPU cycles (even start) or 514 (odd start).
  - cpu_ce resumes on the first CE tick after IDLE.
- Simultaneous events: a DMA-internal $4014 access is impossible; a second CPU write to $4014 cannot occur while the CPU is stalled. Reset mid-DMA aborts immediately to IDLE with cpu_ce released.
- cart_a = owner address for all accesses. cart_d = cpu_d, or the DMA byte (never used, since DMA never writes cart).

Optional Feature:
- Macro DENDY_OPEN_BUS_EN.
- Defined: reads of unmapped addresses, and the upper bits of the $4016/$4017 read data, return the last value driven on the data bus (last cpu_i or write data).
- Undefined: unmapped reads return 8'hFF and joypad upper bits are fixed at 7'b0100000.

Decomposition:
- Package dendy_bus_pkg holds:
  - Address-map constants: RAM_END, PPU_BASE, PPU_END, OAM_DMA=16'h4014, JOY1=16'h4016, JOY2=16'h4017, CART_BASE=16'h4020.
  - PPU_OAMDATA=3'd4.
  - The DMA state enum.
- One sub-module, dendy_oam_dma, containing the DMA FSM, page/index counters and parity alignment. It exposes the bus-request address, write data, strobes and dma_active.

Test Plan:
- RAM mirror: write 8'h5A to $0123, read $0923 and $1923 -> 8'h5A both; exactly one RAM write commit observed.
- PPU strobes: read $3FFA -> ppu_a=3'd2, exactly one ppu_rd pulse per access, cpu_i=ppu_i; write $2006 -> one ppu_wr with ppu_a=3'd6.
- Joypad: joy1=8'b1000_0001, write $4016=1 then 0, nine reads of $4016 -> bit0 sequence 1,0,0,0,0,0,0,1,1.
- OAM DMA even start: preload RAM $0200–$02FF with i^8'hA5, write $4014=8'h02 -> 256 ppu_wr with ppu_a=4, data i^8'hA5 in order; cpu_ce absent for 513 CPU cycles.
- Odd start: same DMA triggered on an odd CPU cycle -> stall of 514 cycles, data identical.
- Reset mid-DMA: assert reset_n=0 at i=100 -> dma_active=0 and strobes 0 immediately (async); after release, cpu_ce resumes every CE_DIV clocks and no further ppu_wr occurs.
